// File: rtl/fdma_wr_feeder.sv
// Upstream stage of the FDMA write channel: buffers a pixel stream in a FIFO and
// hands it to FDMA as BURST_LEN-word packages, rotating across NUM_FRAMES buffers.
module fdma_wr_feeder #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                BURST_LEN    = 64,
    parameter int                FIFO_DEPTH   = 256,
    parameter int                FRAME_WORDS  = 1024*768,
    parameter int                NUM_FRAMES   = 3,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = 32'h0100_0000,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 32'h0040_0000
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESET,
    input  logic              vid_vs,
    input  logic              vid_de,
    input  logic [DATA_W-1:0] vid_data,
    output logic              pkg_wr_areq,
    output logic [ADDR_W-1:0] pkg_wr_addr,
    output logic [ADDR_W-1:0] pkg_wr_size,
    input  logic              pkg_wr_en,
    output logic [DATA_W-1:0] pkg_wr_data,
    input  logic              pkg_wr_last,
    output logic [1:0]        wr_frame_idx,
    output logic [1:0]        done_frame_idx,
    output logic              frame_done,
    output logic              ovf_sticky
);

    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = PTR_W + 1;
    localparam int BYTES_PER_WORD = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_areq;

    logic                r_vs_d;
    logic                r_frame_pend;
    logic                r_frame_active;
    logic                r_buf_used;
    logic [31:0]         r_offset;
    logic [1:0]          r_wr_idx;
    logic [1:0]          r_done_idx;
    logic                r_frame_done;
    logic                r_ovf;
    logic [ADDR_W-1:0]   r_addr;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_vs_rise;
    logic                w_full;
    logic                w_empty;
    logic [31:0]         w_fill;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_switch;
    logic                w_start;
    logic                w_burst_end;
    logic                w_frame_end;
    logic [31:0]         w_offset_next;
    logic [1:0]          w_next_idx;
    logic [ADDR_W-1:0]   w_burst_addr;

    assign w_vs_rise     = vid_vs & ~r_vs_d;
    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_fill        = r_offset + 32'(r_count);
    assign w_push        = vid_de & r_frame_active & ~w_full & (w_fill < 32'(FRAME_WORDS));
    assign w_drop        = vid_de & ~w_push;
    assign w_pop         = pkg_wr_en & ~w_empty;

    // A pending frame switch always wins over starting the next burst.
    assign w_switch      = (r_state == S_IDLE) & r_frame_pend;
    assign w_start       = (r_state == S_IDLE) & ~r_frame_pend & r_frame_active
                         & (r_count >= CNT_W'(BURST_LEN)) & (r_offset < 32'(FRAME_WORDS));
    assign w_burst_end   = (r_state == S_BUSY) & pkg_wr_last;
    assign w_offset_next = r_offset + 32'(BURST_LEN);
    assign w_frame_end   = w_burst_end & (w_offset_next == 32'(FRAME_WORDS));
    assign w_next_idx    = (r_wr_idx == 2'(NUM_FRAMES - 1)) ? 2'd0 : r_wr_idx + 2'd1;
    assign w_burst_addr  = FRAME_BASE
                         + ADDR_W'(r_wr_idx) * FRAME_STRIDE
                         + ADDR_W'(r_offset) * ADDR_W'(BYTES_PER_WORD);

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_areq       = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next_state = S_REQ;
            S_REQ: begin
                w_areq       = 1'b1;
                w_next_state = S_BUSY;
            end
            S_BUSY: if (pkg_wr_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; only the pointers and count define FIFO contents.
    always_ff @(posedge M_AXI_ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= vid_data;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_switch) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_vs_d         <= 1'b0;
            r_frame_pend   <= 1'b0;
            r_frame_active <= 1'b0;
            r_buf_used     <= 1'b0;
            r_offset       <= '0;
            r_wr_idx       <= 2'd0;
            r_done_idx     <= 2'(NUM_FRAMES - 1);
            r_frame_done   <= 1'b0;
            r_ovf          <= 1'b0;
            r_addr         <= FRAME_BASE;
        end else begin
            r_vs_d       <= vid_vs;
            r_frame_done <= w_frame_end;
            if (w_drop && r_frame_active) r_ovf <= 1'b1;

            if (w_vs_rise)     r_frame_pend <= 1'b1;
            else if (w_switch) r_frame_pend <= 1'b0;

            // Advance once any buffer has been claimed, so a completed frame is never overwritten.
            if (w_switch) begin
                if (r_buf_used) r_wr_idx <= w_next_idx;
                r_buf_used     <= 1'b1;
                r_offset       <= '0;
                r_frame_active <= 1'b1;
            end

            if (w_start)     r_addr   <= w_burst_addr;
            if (w_burst_end) r_offset <= w_offset_next;
            if (w_frame_end) begin
                r_done_idx     <= r_wr_idx;
                r_frame_active <= 1'b0;
            end
        end
    end

    assign pkg_wr_areq    = w_areq;
    assign pkg_wr_addr    = r_addr;
    assign pkg_wr_size    = ADDR_W'(BURST_LEN);
    assign pkg_wr_data    = r_mem[r_rd_ptr];
    assign wr_frame_idx   = r_wr_idx;
    assign done_frame_idx = r_done_idx;
    assign frame_done     = r_frame_done;
    assign ovf_sticky     = r_ovf;

endmodule

// File: tb/tb_fdma_wr_feeder.sv
// Bench for fdma_wr_feeder: random pixel streams and a randomly stalling FDMA model,
// checked against a frame/burst-level reference model.
module tb_fdma_wr_feeder;

    localparam int          DW     = 32;
    localparam int          AW     = 32;
    localparam int          BL     = 64;
    localparam int          DEPTH  = 256;
    localparam int          FW     = 256;
    localparam int          NF     = 3;
    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam logic [31:0] STRIDE = 32'h0040_0000;

    logic          clk;
    logic          rst;
    logic          vid_vs;
    logic          vid_de;
    logic [DW-1:0] vid_data;
    logic          pkg_wr_areq;
    logic [AW-1:0] pkg_wr_addr;
    logic [AW-1:0] pkg_wr_size;
    logic          pkg_wr_en;
    logic [DW-1:0] pkg_wr_data;
    logic          pkg_wr_last;
    logic [1:0]    wr_frame_idx;
    logic [1:0]    done_frame_idx;
    logic          frame_done;
    logic          ovf_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] addr_log[$];
    logic [31:0] size_log[$];
    logic [1:0]  idx_log[$];
    logic [31:0] data_log[$];
    logic [1:0]  done_log[$];
    logic [31:0] pix_q[$];
    int          areq_overlap;
    bit          fdma_stall;
    bit          fdma_gaps;
    bit          fdma_busy;
    int          fdma_sent;

    int          m_idx;
    bit          m_used;
    logic [1:0]  m_done;

    fdma_wr_feeder #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
        .FRAME_WORDS(FW), .NUM_FRAMES(NF), .FRAME_BASE(BASE), .FRAME_STRIDE(STRIDE)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .vid_vs(vid_vs),
        .vid_de(vid_de),
        .vid_data(vid_data),
        .pkg_wr_areq(pkg_wr_areq),
        .pkg_wr_addr(pkg_wr_addr),
        .pkg_wr_size(pkg_wr_size),
        .pkg_wr_en(pkg_wr_en),
        .pkg_wr_data(pkg_wr_data),
        .pkg_wr_last(pkg_wr_last),
        .wr_frame_idx(wr_frame_idx),
        .done_frame_idx(done_frame_idx),
        .frame_done(frame_done),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_addr(input int idx, input int burst);
        return BASE + 32'(idx) * STRIDE + 32'(burst * BL * (DW / 8));
    endfunction

    // FDMA model: accepts one package per areq and pulls BL words, optionally with gaps.
    initial begin : fdma_model
        pkg_wr_en   = 1'b0;
        pkg_wr_last = 1'b0;
        fdma_busy   = 1'b0;
        fdma_sent   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pkg_wr_en   = 1'b0;
                pkg_wr_last = 1'b0;
                fdma_busy   = 1'b0;
                fdma_sent   = 0;
            end else begin
                if (frame_done) done_log.push_back(done_frame_idx);
                if (pkg_wr_areq) begin
                    addr_log.push_back(pkg_wr_addr);
                    size_log.push_back(pkg_wr_size);
                    idx_log.push_back(wr_frame_idx);
                    if (fdma_busy) areq_overlap++;
                    fdma_busy = 1'b1;
                    fdma_sent = 0;
                end
                pkg_wr_en   = 1'b0;
                pkg_wr_last = 1'b0;
                if (fdma_busy && !fdma_stall && (!fdma_gaps || $urandom_range(0, 3) != 0)) begin
                    pkg_wr_en   = 1'b1;
                    pkg_wr_last = (fdma_sent == BL - 1);
                    data_log.push_back(pkg_wr_data);
                    fdma_sent++;
                    if (fdma_sent == BL) fdma_busy = 1'b0;
                end
            end
        end
    end

    task automatic clear_logs();
        addr_log.delete(); size_log.delete(); idx_log.delete();
        data_log.delete(); done_log.delete(); pix_q.delete();
        areq_overlap = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; vid_vs = 1'b0; vid_de = 1'b0; vid_data = '0;
        fdma_stall = 1'b0; fdma_gaps = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        m_idx = 0; m_used = 1'b0; m_done = 2'(NF - 1);
    endtask

    task automatic pulse_vs();
        @(negedge clk); vid_vs = 1'b1;
        @(negedge clk); vid_vs = 1'b0;
        if (m_used) m_idx = (m_idx + 1) % NF;
        m_used = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_pixels(input int n, input bit seq, input bit gaps, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vid_de   = 1'b1;
            vid_data = seq ? first + 32'(i) : $urandom();
            pix_q.push_back(vid_data);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                vid_de = 1'b0;
            end
        end
        @(negedge clk);
        vid_de = 1'b0;
    endtask

    task automatic wait_data(input int n, input int budget, output bit ok);
        int c = 0;
        while (data_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (data_log.size() >= n);
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        int c = 0;
        while (done_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (done_log.size() >= n);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (pkg_wr_areq !== 1'b0) $display("FAIL reset_areq: got %0b want 0", pkg_wr_areq); else n_pass++;
        n_checks++; if (pkg_wr_addr !== BASE) $display("FAIL reset_addr: got %h want %h", pkg_wr_addr, BASE); else n_pass++;
        n_checks++; if (pkg_wr_size !== 32'(BL)) $display("FAIL reset_size: got %0d want %0d", pkg_wr_size, BL); else n_pass++;
        n_checks++; if (wr_frame_idx !== 2'd0) $display("FAIL reset_wr_idx: got %0d want 0", wr_frame_idx); else n_pass++;
        n_checks++; if (done_frame_idx !== 2'(NF - 1)) $display("FAIL reset_done_idx: got %0d want %0d", done_frame_idx, NF - 1); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %0b want 0", frame_done); else n_pass++;
        n_checks++; if (ovf_sticky !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf_sticky); else n_pass++;
    endtask

    task automatic test_single_burst();
        bit ok;
        pulse_vs();
        send_pixels(BL, 1'b1, 1'b0, 32'd0);
        wait_data(BL, 500, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout: got %0d words want %0d", data_log.size(), BL); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (addr_log.size() != 1) $display("FAIL single_areq_count: got %0d want 1", addr_log.size()); else n_pass++;
        n_checks++; if (addr_log[0] !== BASE) $display("FAIL single_addr: got %h want %h", addr_log[0], BASE); else n_pass++;
        n_checks++; if (size_log[0] !== 32'(BL)) $display("FAIL single_size: got %0d want %0d", size_log[0], BL); else n_pass++;
        for (int i = 0; i < BL; i++) begin
            n_checks++; if (data_log[i] !== 32'(i)) $display("FAIL single_data[%0d]: got %h want %h", i, data_log[i], i); else n_pass++;
        end
        n_checks++; if (dut.r_count !== '0) $display("FAIL single_fifo_empty: got %0d want 0", dut.r_count); else n_pass++;
    endtask

    task automatic test_frames();
        bit ok;
        apply_reset();
        fdma_gaps = 1'b1;
        for (int f = 0; f < 3; f++) begin
            clear_logs();
            pulse_vs();
            n_checks++; if (wr_frame_idx !== 2'(m_idx)) $display("FAIL frame%0d_wr_idx: got %0d want %0d", f, wr_frame_idx, m_idx); else n_pass++;
            send_pixels(FW, 1'b0, 1'b1, 32'd0);
            wait_done(1, 3000, ok);
            n_checks++; if (!ok) $display("FAIL frame%0d_done_timeout: got %0d pulses want 1", f, done_log.size()); else n_pass++;
            repeat (5) @(negedge clk);
            m_done = 2'(m_idx);
            n_checks++; if (addr_log.size() != FW / BL) $display("FAIL frame%0d_bursts: got %0d want %0d", f, addr_log.size(), FW / BL); else n_pass++;
            for (int b = 0; b < FW / BL; b++) begin
                n_checks++; if (addr_log[b] !== exp_addr(m_idx, b)) $display("FAIL frame%0d_addr[%0d]: got %h want %h", f, b, addr_log[b], exp_addr(m_idx, b)); else n_pass++;
                n_checks++; if (idx_log[b] !== 2'(m_idx)) $display("FAIL frame%0d_areq_idx[%0d]: got %0d want %0d", f, b, idx_log[b], m_idx); else n_pass++;
            end
            for (int i = 0; i < FW; i++) begin
                n_checks++; if (data_log[i] !== pix_q[i]) $display("FAIL frame%0d_data[%0d]: got %h want %h", f, i, data_log[i], pix_q[i]); else n_pass++;
            end
            n_checks++; if (done_log.size() != 1) $display("FAIL frame%0d_done_pulses: got %0d want 1", f, done_log.size()); else n_pass++;
            n_checks++; if (done_log[0] !== m_done) $display("FAIL frame%0d_done_idx_at_pulse: got %0d want %0d", f, done_log[0], m_done); else n_pass++;
            n_checks++; if (done_frame_idx !== m_done) $display("FAIL frame%0d_done_idx: got %0d want %0d", f, done_frame_idx, m_done); else n_pass++;
        end
        pulse_vs();
        n_checks++; if (wr_frame_idx !== 2'(m_idx)) $display("FAIL frames_wrap_idx: got %0d want %0d", wr_frame_idx, m_idx); else n_pass++;
    endtask

    task automatic test_midburst_vs();
        bit ok;
        int  old_idx;
        clear_logs();
        fdma_gaps = 1'b0;
        old_idx   = m_idx;
        fork
            send_pixels(100, 1'b1, 1'b0, 32'd1000);
            begin
                wait_data(40, 800, ok);
                pulse_vs();
            end
        join
        n_checks++; if (!ok) $display("FAIL midvs_timeout: got %0d words want 40", data_log.size()); else n_pass++;
        wait_data(BL, 500, ok);
        repeat (8) @(negedge clk);
        n_checks++; if (data_log.size() != BL) $display("FAIL midvs_words: got %0d want %0d", data_log.size(), BL); else n_pass++;
        n_checks++; if (addr_log.size() != 1) $display("FAIL midvs_areq_count: got %0d want 1", addr_log.size()); else n_pass++;
        n_checks++; if (addr_log[0] !== exp_addr(old_idx, 0)) $display("FAIL midvs_addr: got %h want %h", addr_log[0], exp_addr(old_idx, 0)); else n_pass++;
        for (int i = 0; i < BL; i++) begin
            n_checks++; if (data_log[i] !== 32'(1000 + i)) $display("FAIL midvs_data[%0d]: got %h want %h", i, data_log[i], 1000 + i); else n_pass++;
        end
        n_checks++; if (dut.r_count !== '0) $display("FAIL midvs_flush: got %0d want 0", dut.r_count); else n_pass++;
        n_checks++; if (dut.r_offset !== 32'd0) $display("FAIL midvs_offset: got %0d want 0", dut.r_offset); else n_pass++;
        n_checks++; if (wr_frame_idx !== 2'(m_idx)) $display("FAIL midvs_wr_idx: got %0d want %0d", wr_frame_idx, m_idx); else n_pass++;
        n_checks++; if (done_log.size() != 0) $display("FAIL midvs_no_done: got %0d pulses want 0", done_log.size()); else n_pass++;
        n_checks++; if (done_frame_idx !== m_done) $display("FAIL midvs_done_idx: got %0d want %0d", done_frame_idx, m_done); else n_pass++;
        clear_logs();
        send_pixels(BL, 1'b0, 1'b0, 32'd0);
        wait_data(BL, 500, ok);
        n_checks++; if (!ok) $display("FAIL midvs_next_timeout: got %0d words want %0d", data_log.size(), BL); else n_pass++;
        n_checks++; if (addr_log[0] !== exp_addr(m_idx, 0)) $display("FAIL midvs_next_addr: got %h want %h", addr_log[0], exp_addr(m_idx, 0)); else n_pass++;
        for (int i = 0; i < BL; i++) begin
            n_checks++; if (data_log[i] !== pix_q[i]) $display("FAIL midvs_next_data[%0d]: got %h want %h", i, data_log[i], pix_q[i]); else n_pass++;
        end
    endtask

    task automatic test_stall_overflow();
        bit ok;
        apply_reset();
        pulse_vs();
        n_checks++; if (ovf_sticky !== 1'b0) $display("FAIL stall_ovf_before: got %0b want 0", ovf_sticky); else n_pass++;
        fdma_stall = 1'b1;
        send_pixels(300, 1'b1, 1'b0, 32'd5000);
        repeat (10) @(negedge clk);
        n_checks++; if (dut.r_count !== 9'(DEPTH)) $display("FAIL stall_count: got %0d want %0d", dut.r_count, DEPTH); else n_pass++;
        n_checks++; if (addr_log.size() != 1) $display("FAIL stall_areq_count: got %0d want 1", addr_log.size()); else n_pass++;
        n_checks++; if (data_log.size() != 0) $display("FAIL stall_no_pop: got %0d want 0", data_log.size()); else n_pass++;
        n_checks++; if (ovf_sticky !== 1'b1) $display("FAIL stall_ovf: got %0b want 1", ovf_sticky); else n_pass++;
        fdma_stall = 1'b0;
        wait_done(1, 2000, ok);
        repeat (5) @(negedge clk);
        m_done = 2'(m_idx);
        n_checks++; if (!ok) $display("FAIL stall_done_timeout: got %0d pulses want 1", done_log.size()); else n_pass++;
        n_checks++; if (data_log.size() != DEPTH) $display("FAIL stall_kept_words: got %0d want %0d", data_log.size(), DEPTH); else n_pass++;
        for (int b = 0; b < FW / BL; b++) begin
            n_checks++; if (addr_log[b] !== exp_addr(m_idx, b)) $display("FAIL stall_addr[%0d]: got %h want %h", b, addr_log[b], exp_addr(m_idx, b)); else n_pass++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (data_log[i] !== pix_q[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, data_log[i], pix_q[i]); else n_pass++;
        end
        n_checks++; if (areq_overlap != 0) $display("FAIL stall_areq_in_busy: got %0d want 0", areq_overlap); else n_pass++;
        n_checks++; if (done_frame_idx !== m_done) $display("FAIL stall_done_idx: got %0d want %0d", done_frame_idx, m_done); else n_pass++;
        n_checks++; if (ovf_sticky !== 1'b1) $display("FAIL stall_ovf_sticky: got %0b want 1", ovf_sticky); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        clear_logs();
        pulse_vs();
        n_checks++; if (wr_frame_idx !== 2'(m_idx)) $display("FAIL arst_pre_idx: got %0d want %0d", wr_frame_idx, m_idx); else n_pass++;
        fork
            send_pixels(80, 1'b0, 1'b0, 32'd0);
            begin
                wait_data(20, 800, ok);
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                n_checks++; if (!ok) $display("FAIL arst_busy_timeout: got %0d words want 20", data_log.size()); else n_pass++;
                n_checks++; if (pkg_wr_addr !== BASE) $display("FAIL arst_addr: got %h want %h", pkg_wr_addr, BASE); else n_pass++;
                n_checks++; if (pkg_wr_areq !== 1'b0) $display("FAIL arst_areq: got %0b want 0", pkg_wr_areq); else n_pass++;
                n_checks++; if (wr_frame_idx !== 2'd0) $display("FAIL arst_wr_idx: got %0d want 0", wr_frame_idx); else n_pass++;
                n_checks++; if (done_frame_idx !== 2'(NF - 1)) $display("FAIL arst_done_idx: got %0d want %0d", done_frame_idx, NF - 1); else n_pass++;
                n_checks++; if (frame_done !== 1'b0) $display("FAIL arst_frame_done: got %0b want 0", frame_done); else n_pass++;
                n_checks++; if (ovf_sticky !== 1'b0) $display("FAIL arst_ovf: got %0b want 0", ovf_sticky); else n_pass++;
                n_checks++; if (dut.r_count !== '0) $display("FAIL arst_fifo: got %0d want 0", dut.r_count); else n_pass++;
            end
        join
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        m_idx = 0; m_used = 1'b0; m_done = 2'(NF - 1);
        send_pixels(2 * BL, 1'b0, 1'b0, 32'd0);
        repeat (50) @(negedge clk);
        n_checks++; if (addr_log.size() != 0) $display("FAIL arst_no_areq: got %0d want 0", addr_log.size()); else n_pass++;
        clear_logs();
        pulse_vs();
        send_pixels(BL, 1'b1, 1'b0, 32'hA000);
        wait_data(BL, 500, ok);
        n_checks++; if (!ok) $display("FAIL arst_restart_timeout: got %0d words want %0d", data_log.size(), BL); else n_pass++;
        n_checks++; if (addr_log[0] !== exp_addr(m_idx, 0)) $display("FAIL arst_restart_addr: got %h want %h", addr_log[0], exp_addr(m_idx, 0)); else n_pass++;
        n_checks++; if (data_log[0] !== 32'hA000) $display("FAIL arst_restart_first: got %h want %h", data_log[0], 32'hA000); else n_pass++;
        n_checks++; if (data_log[BL - 1] !== 32'hA000 + 32'(BL - 1)) $display("FAIL arst_restart_last: got %h want %h", data_log[BL - 1], 32'hA000 + 32'(BL - 1)); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; vid_vs = 1'b0; vid_de = 1'b0; vid_data = '0;
        fdma_stall = 1'b0; fdma_gaps = 1'b0; areq_overlap = 0;
        test_reset();
        test_single_burst();
        test_frames();
        test_midburst_vs();
        test_stall_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
